// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between the memory stage and the data RAM responder
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-word data RAM responder with configurable wait states
module data_mem_responder #(
    parameter int AW   = 10,
    parameter int WAIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = (WAIT > 1) ? $clog2(WAIT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_S, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [15:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [15:0]   mem [DEPTH];

    logic          commit;
    logic          mem_we;
    logic          c_wr;
    logic [31:0]   c_addr;
    logic [15:0]   c_wdata;
    logic          c_in_range;
    logic [AW-1:0] c_idx;

    // With WAIT=0 the commit happens on the accept edge, so the live request
    // fields are used; otherwise the copy latched at acceptance.
    always_comb begin
        if (state_q == IDLE) begin
            c_wr    = bus.req_wr;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
        end else begin
            c_wr    = wr_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
        c_in_range = ((c_addr >> AW) == 32'd0);
        c_idx      = c_addr[AW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CW'(WAIT - 1);
                        state_d = WAIT_S;
                    end
                end
            end
            WAIT_S: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 16'h0000;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !c_in_range;
            rsp_rdata_d = (c_in_range && !c_wr) ? mem[c_idx] : 16'h0000;
        end
    end

    // Reset gates the write so an aborted transaction never reaches the RAM.
    assign mem_we = commit && c_wr && c_in_range && rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench for data_mem_responder with WAIT=2 and WAIT=0 instances
module tb_data_mem_responder;
    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    data_mem_responder_if a_if ();
    data_mem_responder_if b_if ();

    data_mem_responder #(.AW(10), .WAIT(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    data_mem_responder #(.AW(10), .WAIT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT=2 instance; lat is the cycle index
    // (accept edge ends cycle 0) where rsp_valid first shows, 0 on timeout.
    task automatic txn_a(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                         output logic [15:0] rd, output logic err, output int lat);
        a_if.req_valid = 1'b1;
        a_if.req_wr    = wr;
        a_if.req_addr  = addr;
        a_if.req_wdata = wd;
        a_if.rsp_ready = 1'b1;
        tick();
        a_if.req_valid = 1'b0;
        a_if.req_wr    = ~wr;
        a_if.req_addr  = 32'hFFFF_FFFF;
        a_if.req_wdata = ~wd;
        lat = 0;
        rd  = 16'h0000;
        err = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (a_if.rsp_valid) begin
                lat = i;
                rd  = a_if.rsp_rdata;
                err = a_if.rsp_err;
                break;
            end
            tick();
        end
        if (lat != 0) tick();
    endtask

    logic [15:0] rd;
    logic        err;
    int          lat;
    logic        seen;

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b0;
        a_if.req_valid = 1'b0; a_if.req_wr = 1'b0; a_if.req_addr = 32'd0;
        a_if.req_wdata = 16'h0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_wr = 1'b0; b_if.req_addr = 32'd0;
        b_if.req_wdata = 16'h0; b_if.rsp_ready = 1'b0;

        tick();
        tick();
        rst = 1'b1;
        check("rst_req_ready", a_if.req_ready, 1);
        check("rst_rsp_valid", a_if.rsp_valid, 0);
        check("rst_rsp_rdata", a_if.rsp_rdata, 0);
        check("rst_rsp_err",   a_if.rsp_err, 0);
        check("rst_busy",      a_if.busy, 0);
        check("rst_b_ready",   b_if.req_ready, 1);

        a_if.req_valid = 1'b1; a_if.req_wr = 1'b1;
        a_if.req_addr = 32'h5; a_if.req_wdata = 16'hBEEF; a_if.rsp_ready = 1'b1;
        tick();
        a_if.req_valid = 1'b0;
        check("wr_c1_busy",  a_if.busy, 1);
        check("wr_c1_ready", a_if.req_ready, 0);
        check("wr_c1_valid", a_if.rsp_valid, 0);
        tick();
        check("wr_c2_valid", a_if.rsp_valid, 0);
        tick();
        check("wr_c3_valid", a_if.rsp_valid, 1);
        check("wr_c3_rdata", a_if.rsp_rdata, 0);
        check("wr_c3_err",   a_if.rsp_err, 0);
        tick();
        check("wr_c4_valid", a_if.rsp_valid, 0);
        check("wr_c4_ready", a_if.req_ready, 1);

        txn_a(1'b0, 32'h5, 16'h0, rd, err, lat);
        check("rd5_lat",   lat, 3);
        check("rd5_rdata", rd, 16'hBEEF);
        check("rd5_err",   err, 0);

        a_if.rsp_ready = 1'b0;
        a_if.req_valid = 1'b1; a_if.req_wr = 1'b0; a_if.req_addr = 32'h5;
        tick();
        a_if.req_valid = 1'b0;
        tick();
        tick();
        check("bp_valid0", a_if.rsp_valid, 1);
        check("bp_rdata0", a_if.rsp_rdata, 16'hBEEF);
        a_if.req_valid = 1'b1; a_if.req_wr = 1'b1;
        a_if.req_addr = 32'h5; a_if.req_wdata = 16'h0BAD;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", a_if.rsp_valid, 1);
            check("bp_rdata", a_if.rsp_rdata, 16'hBEEF);
            check("bp_ready", a_if.req_ready, 0);
        end
        a_if.req_valid = 1'b0;
        a_if.rsp_ready = 1'b1;
        tick();
        check("bp_done_ready", a_if.req_ready, 1);
        check("bp_done_valid", a_if.rsp_valid, 0);
        check("bp_done_rdata", a_if.rsp_rdata, 0);

        txn_a(1'b0, 32'h5, 16'h0, rd, err, lat);
        check("bp_ignored_wr", rd, 16'hBEEF);

        txn_a(1'b1, 32'h0, 16'h5A5A, rd, err, lat);
        check("wr0_err", err, 0);
        txn_a(1'b1, 32'h400, 16'h1234, rd, err, lat);
        check("oor_wr_lat",   lat, 3);
        check("oor_wr_err",   err, 1);
        check("oor_wr_rdata", rd, 0);
        txn_a(1'b0, 32'h0, 16'h0, rd, err, lat);
        check("rd0_rdata", rd, 16'h5A5A);
        check("rd0_err",   err, 0);
        txn_a(1'b0, 32'h0001_0000, 16'h0, rd, err, lat);
        check("oor_rd_err",   err, 1);
        check("oor_rd_rdata", rd, 0);

        b_if.req_valid = 1'b1; b_if.req_wr = 1'b1;
        b_if.req_addr = 32'h3; b_if.req_wdata = 16'h3C3C; b_if.rsp_ready = 1'b1;
        tick();
        check("w0_c1_valid", b_if.rsp_valid, 1);
        check("w0_c1_err",   b_if.rsp_err, 0);
        check("w0_c1_rdata", b_if.rsp_rdata, 0);
        b_if.req_wr = 1'b0;
        tick();
        check("w0_c2_ready", b_if.req_ready, 1);
        check("w0_c2_valid", b_if.rsp_valid, 0);
        tick();
        check("w0_c3_valid", b_if.rsp_valid, 1);
        check("w0_c3_rdata", b_if.rsp_rdata, 16'h3C3C);
        b_if.req_valid = 1'b0;
        tick();
        check("w0_c4_valid", b_if.rsp_valid, 0);

        txn_a(1'b1, 32'h7, 16'h1111, rd, err, lat);
        a_if.req_valid = 1'b1; a_if.req_wr = 1'b1;
        a_if.req_addr = 32'h7; a_if.req_wdata = 16'hAAAA;
        tick();
        a_if.req_valid = 1'b0;
        check("abort_busy_pre", a_if.busy, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy",  a_if.busy, 0);
        check("abort_valid", a_if.rsp_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_if.rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);
        txn_a(1'b0, 32'h7, 16'h0, rd, err, lat);
        check("abort_rd7", rd, 16'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU's data-memory request interface. It serves single-word (16-bit) read/write requests from the memory stage, including stack push/pop traffic addressed via SP, using a valid/ready request channel and a valid/ready response channel. It models a synchronous data RAM with a configurable number of wait states, so the pipeline's keep/stall logic can be exercised against a multi-cycle memory.

Parameters:
AW, 10, word-index width; DEPTH = 2**AW 16-bit words
WAIT, 2, wait cycles inserted between request accept and response (0 allowed)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous reset, active-low
req_valid  in  1  requester presents a request
req_ready  out  1  responder can accept a request this cycle
req_wr  in  1  1 = write, 0 = read
req_addr  in  32  word address (SP value or zero-extended ALU result)
req_wdata  in  16  write data
rsp_valid  out  1  response available
rsp_ready  in  1  requester consumes the response
rsp_rdata  out  16  read data; 0 for writes and errors
rsp_err  out  1  address out of range (req_addr >= DEPTH)
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset: rst sampled low at a rising edge -> state IDLE, wait counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0. RAM contents are not cleared. A transaction in flight is aborted; an uncommitted write is never performed.
- FSM states: IDLE, WAIT_S, RESP.
- req_ready = (state==IDLE) and is driven combinationally from state only, never from req_valid. busy = !req_ready.
- IDLE: if req_valid at the edge, latch req_wr, req_addr, and req_wdata. Then go to WAIT_S with counter=WAIT-1 if WAIT>0; otherwise go directly to RESP, committing at that edge.
- WAIT_S: decrement the counter each edge. At the edge where the counter is 0, commit and go to RESP.
- Commit, at a single edge:
  - in-range write: RAM[addr[AW-1:0]] <= wdata; rsp_rdata=0; rsp_err=0.
  - in-range read: rsp_rdata <= RAM[addr[AW-1:0]]; rsp_err=0.
  - out of range (any addr bit above AW-1 set): no RAM write; rsp_rdata=0; rsp_err=1.
  - In all three cases rsp_valid <= 1.
- Latency: if the request is accepted at the end of cycle 0, rsp_valid is high from cycle WAIT+1.
- RESP: rsp_valid, rsp_rdata, and rsp_err are held stable until rsp_valid&&rsp_ready at an edge. At that edge rsp_valid<=0, rsp_rdata and rsp_err are cleared to 0, and the state goes to IDLE. If rsp_ready is already high on the first RESP cycle, the response lasts exactly 1 cycle.
- Throughput: one transaction per WAIT+2 cycles at best. A new request is accepted no earlier than the cycle after the response handshake.
- req_valid is ignored outside IDLE. The requester holds request fields stable until accepted; the latched copy is used afterward, so changes after acceptance have no effect.
- Ordering: transactions are strictly serialized, so a read following a write to the same address returns the new data.
- Address wrap: none. Addresses >= DEPTH always error, including SP-region addresses above 2**AW.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
- Write then read, WAIT=2, rsp_ready tied 1:
  - write addr=0x5, data=0xBEEF accepted cycle 0 -> rsp_valid only in cycle 3, rsp_err=0, rsp_rdata=0.
  - read addr=0x5 accepted cycle 4 -> rsp_valid in cycle 7 with rsp_rdata=0xBEEF.
- Backpressure: read addr=0x5 with rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid/rsp_rdata=0xBEEF held stable; req_ready=0 and a second req_valid is ignored; rsp_ready=1 -> IDLE next cycle.
- Out of range: write addr=0x400 (AW=10), data=0x1234 -> rsp_err=1, rsp_rdata=0; a subsequent read of addr=0x0 returns the previous value, unchanged.
- WAIT=0 build: read accepted cycle 0 -> rsp_valid in cycle 1; back-to-back requests accepted in cycles 0 and 2.
- Reset mid-operation: write addr=0x7, data=0xAAAA accepted, rst=0 during WAIT_S -> no response; a read of 0x7 after reset returns the prior content, not 0xAAAA.
